// File: rtl/bbqm_pkg.sv
// Shared widths, limits and count-update decode for the bank queue manager.
// The wait-time lookup imports this package too.
package bbqm_pkg;

  localparam int PCOUNT_W   = 4;
  localparam int TCOUNT_W   = 2;
  localparam int MAX_PEOPLE = 7;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  // A simultaneous arrival and departure cancel, except at the rails.
  // At the rails the arrival is taken first at empty and the departure first at full.
  function automatic cnt_op_e count_op(input logic arrive, input logic depart,
                                       input logic is_empty, input logic is_full);
    cnt_op_e op;
    op = CNT_HOLD;
    case ({arrive, depart})
      2'b10:   op = is_full  ? CNT_HOLD : CNT_INC;
      2'b01:   op = is_empty ? CNT_HOLD : CNT_DEC;
      2'b11: begin
        if (is_empty)     op = CNT_INC;
        else if (is_full) op = CNT_DEC;
      end
      default: op = CNT_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bbqm_sensor_debounce.sv
// Two-flop synchroniser, consecutive-cycle debounce and rising-edge detector
// for one raw photo-sensor level.
module bbqm_sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_db_q;

  // Any cycle where s2 agrees with the debounced level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
    end else begin
      r_s1   <= raw;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level      = r_db;
  assign rise_pulse = r_db & ~r_db_q;

endmodule

// File: rtl/bbqm_people_counter.sv
// Queue occupancy front end: debounced entry/exit events drive a saturating
// people count with full/empty flags and reject pulses; teller switches are synchronised.
module bbqm_people_counter
  import bbqm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_COUNT       = MAX_PEOPLE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                front_sensor,
  input  logic                back_sensor,
  input  logic [TCOUNT_W-1:0] tcount_sw,
  output logic [PCOUNT_W-1:0] Pcount,
  output logic [TCOUNT_W-1:0] Tcount,
  output logic                empty_flag,
  output logic                full_flag,
  output logic                arrive_rej,
  output logic                depart_rej
);

  localparam logic [PCOUNT_W-1:0] MAX_P = PCOUNT_W'(MAX_COUNT);
  localparam int WARM_W = $clog2(DEBOUNCE_CYCLES + 4);
  localparam logic [WARM_W-1:0] WARM = WARM_W'(DEBOUNCE_CYCLES + 3);

  logic                w_front_level;
  logic                w_front_rise;
  logic                w_back_level;
  logic                w_back_rise;
  logic [WARM_W-1:0]   r_warm;
  logic                w_warm_done;
  logic                r_front_armed;
  logic                r_back_armed;
  logic                w_arrive;
  logic                w_depart;
  cnt_op_e             w_op;
  logic [PCOUNT_W-1:0] w_pcount_next;
  logic                w_arej;
  logic                w_drej;
  logic [PCOUNT_W-1:0] r_pcount;
  logic                r_empty;
  logic                r_full;
  logic                r_arej;
  logic                r_drej;
  logic [TCOUNT_W-1:0] r_tsync1;
  logic [TCOUNT_W-1:0] r_tsync2;

  bbqm_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_front_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (front_sensor),
    .level      (w_front_level),
    .rise_pulse (w_front_rise)
  );

  bbqm_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (back_sensor),
    .level      (w_back_level),
    .rise_pulse (w_back_rise)
  );

  // A sensor held high through reset would otherwise debounce high and look like
  // a fresh arrival; only arm once the debounced level has had time to settle low.
  assign w_warm_done = (r_warm == WARM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm        <= '0;
      r_front_armed <= 1'b0;
      r_back_armed  <= 1'b0;
    end else begin
      if (!w_warm_done) r_warm <= r_warm + WARM_W'(1);
      r_front_armed <= r_front_armed | (w_warm_done & ~w_front_level);
      r_back_armed  <= r_back_armed  | (w_warm_done & ~w_back_level);
    end
  end

  assign w_arrive = w_front_rise & r_front_armed;
  assign w_depart = w_back_rise  & r_back_armed;

  always_comb begin
    w_pcount_next = r_pcount;
    w_op          = count_op(w_arrive, w_depart, r_empty, r_full);
    case (w_op)
      CNT_INC: w_pcount_next = r_pcount + PCOUNT_W'(1);
      CNT_DEC: w_pcount_next = r_pcount - PCOUNT_W'(1);
      default: w_pcount_next = r_pcount;
    endcase
    w_arej = w_arrive & ~w_depart & r_full;
    w_drej = w_depart & ~w_arrive & r_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcount <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_arej   <= 1'b0;
      r_drej   <= 1'b0;
      r_tsync1 <= '0;
      r_tsync2 <= '0;
    end else begin
      r_pcount <= w_pcount_next;
      r_empty  <= (w_pcount_next == '0);
      r_full   <= (w_pcount_next == MAX_P);
      r_arej   <= w_arej;
      r_drej   <= w_drej;
      r_tsync1 <= tcount_sw;
      r_tsync2 <= r_tsync1;
    end
  end

  assign Pcount     = r_pcount;
  assign Tcount     = r_tsync2;
  assign empty_flag = r_empty;
  assign full_flag  = r_full;
  assign arrive_rej = r_arej;
  assign depart_rej = r_drej;

endmodule
